// File: rtl/mem_stream_reader.sv
// mem_stream_reader: streams a contiguous RAM word range out as one Avalon-ST packet through a 2-entry buffer.
module mem_stream_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_startofpacket,
  output logic              out_endofpacket
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int EW = DATA_W + 2;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [EW-1:0]     b0_q, b0_d, b1_q, b1_d;
  logic [1:0]        occ_q, occ_d, tag_q, tag_d;
  logic              inf_q, inf_d, done_q, done_d, aborted_q, aborted_d;
  logic [EW-1:0]     inc, head;
  logic              issue, pop, last, active;
  // Entries are {sop, eop, data}; the word arriving from RAM is presented directly when the buffer is empty.
  assign inc               = {tag_q, mem_readdata};
  assign head              = (occ_q != 2'd0) ? b0_q : inc;
  assign out_valid         = (occ_q != 2'd0) || inf_q;
  assign out_data          = head[DATA_W-1:0];
  assign out_startofpacket = out_valid & head[DATA_W+1];
  assign out_endofpacket   = out_valid & head[DATA_W];
  assign pop               = out_valid & out_ready;
  assign active            = state_q != IDLE;
  assign busy              = active;
  assign done              = done_q;
  assign aborted           = aborted_q;
  assign last              = cnt_q == len_q - (ADDR_W+1)'(1);
  assign issue             = (state_q == RUN) && !abort &&
                             (({1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop}) < 3'd2);
  assign mem_chipselect    = issue;
  assign mem_address       = addr_q;
  assign mem_clken         = 1'b1;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    inf_d     = issue;
    occ_d     = occ_q + {1'b0, inf_q} - {1'b0, pop};
    b0_d      = pop ? ((occ_q == 2'd2) ? b1_q : inc) : ((occ_q == 2'd0) ? inc : b0_q);
    b1_d      = (pop || occ_q == 2'd1) ? inc : b1_q;
    if (issue) begin
      cnt_d  = cnt_q + (ADDR_W+1)'(1);
      addr_d = addr_q + ADDR_W'(1);
      tag_d  = {cnt_q == '0, last};
      if (last) state_d = DRAIN;
    end
    if (state_q == IDLE && start) begin
      if (length == '0) done_d = 1'b1;
      else begin
        len_d   = length;
        cnt_d   = '0;
        addr_d  = base;
        state_d = RUN;
      end
    end
    if (state_q == DRAIN && pop && head[DATA_W]) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
    if (active && abort) begin
      state_d   = IDLE;
      occ_d     = 2'd0;
      inf_d     = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      tag_q     <= '0;
      occ_q     <= '0;
      inf_q     <= 1'b0;
      b0_q      <= '0;
      b1_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      occ_q     <= occ_d;
      inf_q     <= inf_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: table of transfers checked against a packet-level model of the expected beat stream.
module tb_mem_stream_reader;
  localparam int AW = 12;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] base;
  logic [AW:0]   length;
  logic          busy, done, aborted, mem_chipselect, mem_clken;
  logic          out_valid, out_startofpacket, out_endofpacket;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_readdata, out_data;
  logic [DW-1:0] ram [4096];
  typedef struct {
    int base; int len; int mode; int abort_at; int reset_at;
    int exp_beats; int exp_done; int exp_ab;
  } vec_t;
  vec_t tbl [11];
  int n_checks = 0, n_fail = 0;
  int m_busy = 0, m_base = 0, m_len = 0, m_issued = 0, m_beats = 0, m_cyc = 0;
  int e_done = 0, e_ab = 0, n_done = 0, n_ab = 0, timed = 0;
  int stall = 0;
  logic [DW-1:0] s_data;
  logic [2:0]    s_flags;

  mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .base(base), .length(length),
    .busy(busy), .done(done), .aborted(aborted), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket)
  );

  always #5 clk = ~clk;
  // Single-cycle-latency RAM; junk on the bus whenever no read was issued.
  always @(posedge clk) mem_readdata <= mem_chipselect ? ram[mem_address] : $urandom();

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic pop;
    int k;
    @(negedge clk);
    if (m_busy != 0) m_cyc++;
    pop = out_valid & out_ready;
    chk("busy", busy, m_busy != 0);
    chk("done", done, e_done != 0);
    chk("aborted", aborted, e_ab != 0);
    if (done) n_done++;
    if (aborted) n_ab++;
    if (m_busy == 0)
      chk("idle_outputs", {out_valid, out_startofpacket, out_endofpacket, mem_chipselect}, 0);
    if (stall != 0) begin
      chk("stall_data", out_data, s_data);
      chk("stall_flags", {out_valid, out_startofpacket, out_endofpacket}, s_flags);
    end
    if (mem_chipselect) begin
      chk("addr", mem_address, (m_base + m_issued) % 4096);
      chk("room", (m_issued - m_beats - int'(pop)) < 2, 1);
      chk("over_issue", m_issued < m_len, 1);
      chk("issue_on_abort", abort, 0);
      m_issued++;
    end
    if (pop && m_busy != 0) begin
      k = m_beats;
      chk("beat_index", k < m_len, 1);
      chk("data", out_data, ram[(m_base + k) % 4096]);
      chk("sop", out_startofpacket, k == 0);
      chk("eop", out_endofpacket, k == m_len - 1);
      if (timed != 0) chk("beat_time", m_cyc, 2 + k);
      m_beats++;
    end
    stall = (m_busy != 0 && out_valid && !out_ready && !abort && !reset) ? 1 : 0;
    s_data = out_data;
    s_flags = {out_valid, out_startofpacket, out_endofpacket};
    e_done = 0;
    e_ab = 0;
    if (reset) m_busy = 0;
    else if (m_busy != 0 && abort) begin e_ab = 1; m_busy = 0; end
    else if (m_busy != 0 && pop && m_beats == m_len) begin e_done = 1; m_busy = 0; end
    else if (m_busy == 0 && start) begin
      if (length == 0) e_done = 1;
      else begin
        m_busy = 1; m_base = int'(base); m_len = int'(length);
        m_issued = 0; m_beats = 0; m_cyc = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int fired;
    reset = 0; start = 0; abort = 0; out_ready = 1;
    step();
    step();
    n_done = 0; n_ab = 0; m_beats = 0; fired = 0;
    timed = (v.mode == 0 && v.abort_at < 0 && v.reset_at < 0) ? 1 : 0;
    base = AW'(v.base); length = (AW+1)'(v.len); start = 1; abort = (v.mode == 2);
    step();
    start = 0; abort = 0;
    for (int c = 0; c < 20000 && (m_busy != 0 || e_done != 0 || e_ab != 0); c++) begin
      out_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      start = (m_busy != 0 && v.mode == 2 && $urandom_range(0, 3) == 0);
      base = AW'($urandom());
      length = (AW+1)'($urandom_range(0, 4096));
      abort = 0; reset = 0;
      if (fired == 0 && m_busy != 0 && v.abort_at >= 0 && m_beats == v.abort_at) begin
        abort = 1; out_ready = 0; fired = 1;
      end
      if (fired == 0 && m_busy != 0 && v.reset_at >= 0 && m_beats == v.reset_at) begin
        reset = 1; out_ready = 0; fired = 1;
      end
      step();
    end
    start = 0; abort = 0; reset = 0;
    chk("finished", (m_busy != 0 || e_done != 0 || e_ab != 0), 0);
    chk("beats", m_beats, v.exp_beats);
    chk("done_pulses", n_done, v.exp_done);
    chk("abort_pulses", n_ab, v.exp_ab);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = DW'(i);
    tbl[0]  = '{'h010, 4, 0, -1, -1, 4, 1, 0};
    tbl[1]  = '{'hFFE, 4, 0, -1, -1, 4, 1, 0};
    tbl[2]  = '{'h100, 8, 1, -1, -1, 8, 1, 0};
    tbl[3]  = '{'h200, 0, 0, -1, -1, 0, 1, 0};
    tbl[4]  = '{'h300, 16, 0, 5, -1, 5, 0, 1};
    tbl[5]  = '{'h020, 3, 0, -1, -1, 3, 1, 0};
    tbl[6]  = '{'h400, 100, 0, -1, 30, 30, 0, 0};
    tbl[7]  = '{'h050, 1, 2, -1, -1, 1, 1, 0};
    tbl[8]  = '{'hFF0, 40, 2, -1, -1, 40, 1, 0};
    tbl[9]  = '{'h000, 4096, 0, -1, -1, 4096, 1, 0};
    tbl[10] = '{int'($urandom_range(0, 4095)), 20, 2, 7, -1, 7, 0, 1};
    reset = 1; start = 0; abort = 0; out_ready = 1; base = '0; length = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("clken_in_reset", mem_clken, 1);
    chk("reset_outputs", {busy, done, aborted, out_valid, out_startofpacket, out_endofpacket, mem_chipselect}, 0);
    reset = 0;
    abort = 1;
    step();
    abort = 0;
    step();
    for (int t = 0; t < 11; t++) run(tbl[t]);
    start = 0; abort = 0; reset = 0; out_ready = 1;
    base = AW'('h7FF); length = (AW+1)'(2); start = 1;
    step();
    start = 0; out_ready = 0;
    repeat (4) step();
    out_ready = 1;
    for (int c = 0; c < 20 && (m_busy != 0 || e_done != 0); c++) step();
    chk("hand_finished", m_busy, 0);
    chk("hand_beats", m_beats, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
